fnd_scan_disp: RTL and testbench

- Display stage downstream of the seconds/minutes counter chain (cnt6 outputs, 0..59 each).
- Accepts a min/sec pair through a valid/ready handshake.
- Converts each value to two BCD digits with a sequential 6-step double-dabble.
- Drives a 4-digit multiplexed 7-segment (FND) display as mm.ss, scanning one digit at a time.

---
 rtl/fnd_pkg.sv | 48 ++++
 rtl/fnd_bin2bcd.sv | 46 ++++
 rtl/fnd_scan_disp.sv | 122 ++++++++++++
 tb/tb_fnd_scan_disp.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared types, segment patterns and helpers for the FND scan display.
package fnd_pkg;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_e;

  // Segment patterns, bit0 = a ... bit6 = g, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Digit slot indices in scan order
  localparam logic [1:0] DIG_SEC1  = 2'd0;
  localparam logic [1:0] DIG_SEC10 = 2'd1;
  localparam logic [1:0] DIG_MIN1  = 2'd2;
  localparam logic [1:0] DIG_MIN10 = 2'd3;

  localparam int unsigned BCD_STEPS = 6;

  function automatic logic [6:0] seg7_of(input logic [3:0] n);
    case (n)
      4'd0:    seg7_of = SEG_0;
      4'd1:    seg7_of = SEG_1;
      4'd2:    seg7_of = SEG_2;
      4'd3:    seg7_of = SEG_3;
      4'd4:    seg7_of = SEG_4;
      4'd5:    seg7_of = SEG_5;
      4'd6:    seg7_of = SEG_6;
      4'd7:    seg7_of = SEG_7;
      4'd8:    seg7_of = SEG_8;
      4'd9:    seg7_of = SEG_9;
      default: seg7_of = SEG_BLANK;
    endcase
  endfunction

  // Counter chain values never exceed 59; anything larger is saturated.
  function automatic logic [5:0] clamp59(input logic [5:0] v);
    clamp59 = (v > 6'd59) ? 6'd59 : v;
  endfunction

endpackage

// File: rtl/fnd_bin2bcd.sv
// Sequential 6-bit binary to 2-digit BCD converter (shift-and-add-3).
// start_i loads the value; six steps follow; done_o flags the last step cycle,
// and bcd_o is valid from the cycle after done_o.
module fnd_bin2bcd
  import fnd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [5:0] bin_i,
  output logic       done_o,
  output logic [7:0] bcd_o
);

  logic [13:0] sh_q, adj_d;
  logic [2:0]  step_q;
  logic        run_q;

  // Add-3 correction on each BCD nibble before the shift
  always_comb begin
    adj_d = sh_q;
    if (sh_q[9:6] >= 4'd5)   adj_d[9:6]   = sh_q[9:6] + 4'd3;
    if (sh_q[13:10] >= 4'd5) adj_d[13:10] = sh_q[13:10] + 4'd3;
  end

  // Load on start, then one correct-and-shift per cycle for six cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      step_q <= '0;
      run_q  <= 1'b0;
    end else if (start_i) begin
      sh_q   <= {8'd0, bin_i};
      step_q <= '0;
      run_q  <= 1'b1;
    end else if (run_q) begin
      sh_q   <= adj_d << 1;
      step_q <= step_q + 3'd1;
      if (step_q == 3'(BCD_STEPS - 1)) run_q <= 1'b0;
    end
  end

  assign done_o = run_q && (step_q == 3'(BCD_STEPS - 1));
  assign bcd_o  = sh_q[13:6];

endmodule

// File: rtl/fnd_scan_disp.sv
// mm.ss 4-digit multiplexed 7-segment display driver with valid/ready input.
// Optional macro FND_BLINK_EN: the mm.ss separator toggles on every load
// instead of staying steadily lit.
module fnd_scan_disp
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] sec_i,
  input  logic [5:0] min_i,
  output logic       busy,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic [3:0] com_o
);

  state_e           state_q;
  logic [3:0][3:0]  disp_q;   // [0]=sec ones .. [3]=min tens
  logic [CNT_W-1:0] div_q;
  logic [1:0]       dig_q;
  logic             accept;
  logic             sec_done, min_done;
  logic [7:0]       sec_bcd, min_bcd;
  logic [3:0]       nib_d;
  logic [6:0]       seg_d;
  logic [3:0]       com_d;
  logic             dp_d;
  logic             sep_on;

  assign accept = in_valid && in_ready;

  fnd_bin2bcd u_sec (
    .clk(clk), .rst(rst), .start_i(accept), .bin_i(clamp59(sec_i)),
    .done_o(sec_done), .bcd_o(sec_bcd)
  );

  fnd_bin2bcd u_min (
    .clk(clk), .rst(rst), .start_i(accept), .bin_i(clamp59(min_i)),
    .done_o(min_done), .bcd_o(min_bcd)
  );

`ifdef FND_BLINK_EN
  logic blink_q;

  // Separator flop flips once per completed update
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  blink_q <= 1'b0;
    else if (state_q == LOAD) blink_q <= ~blink_q;
  end

  assign sep_on = blink_q;
`else
  assign sep_on = 1'b1;
`endif

  // Handshake FSM: accept, wait for both converters, commit digits in one shot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      disp_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          state_q  <= CONV;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        CONV: if (sec_done && min_done) state_q <= LOAD;
        LOAD: begin
          disp_q   <= {min_bcd, sec_bcd};
          state_q  <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Slot divider; a load never disturbs it so the scan stays even
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      dig_q <= DIG_SEC1;
    end else if (div_q == CNT_W'(SCAN_DIV - 1)) begin
      div_q <= '0;
      dig_q <= dig_q + 2'd1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Per-slot decode with leading-zero blanking on the minutes tens digit
  always_comb begin
    nib_d = disp_q[dig_q];
    seg_d = seg7_of(nib_d);
    if (dig_q == DIG_MIN10 && nib_d == 4'd0) seg_d = SEG_BLANK;
    com_d = ~(4'b0001 << dig_q);
    dp_d  = (dig_q == DIG_MIN1) ? sep_on : 1'b0;
  end

  // Registered pad drivers; all digits dark while in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_o <= SEG_BLANK;
      com_o <= 4'b1111;
      dp_o  <= 1'b0;
    end else begin
      seg_o <= seg_d;
      com_o <= com_d;
      dp_o  <= dp_d;
    end
  end

endmodule

// File: tb/tb_fnd_scan_disp.sv
// Self-checking bench for fnd_scan_disp (SCAN_DIV=4).
module tb_fnd_scan_disp;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [5:0] sec_i = '0;
  logic [5:0] min_i = '0;
  logic       in_ready, busy, dp_o;
  logic [6:0] seg_o;
  logic [3:0] com_o;

  int n_chk = 0;
  int n_fail = 0;
  int k;                 // edges since reset release
  int m_sec = 0, m_min = 0;
  bit m_blink = 1'b0;

  fnd_scan_disp #(.SCAN_DIV(SCAN_DIV), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sec_i(sec_i), .min_i(min_i), .busy(busy),
    .seg_o(seg_o), .dp_o(dp_o), .com_o(com_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  function automatic logic [6:0] pat(input int v);
    logic [6:0] t [10];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return t[v];
  endfunction

  function automatic int dig_val(input int d);
    case (d)
      0: return m_sec % 10;
      1: return m_sec / 10;
      2: return m_min % 10;
      default: return m_min / 10;
    endcase
  endfunction

  function automatic bit sep_exp();
`ifdef FND_BLINK_EN
    return m_blink;
`else
    return 1'b1;
`endif
  endfunction

  // Slot after edge k covers digit ((k-1)/SCAN_DIV) mod 4
  task automatic check_scan(input string nm, input int cycles);
    int d, v;
    logic [3:0] ecom;
    logic [6:0] eseg;
    logic       edp;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      d    = ((k - 1) / SCAN_DIV) % 4;
      ecom = ~(4'b0001 << d);
      v    = dig_val(d);
      eseg = (d == 3 && v == 0) ? 7'h00 : pat(v);
      edp  = (d == 2) ? sep_exp() : 1'b0;
      n_chk++;
      if ({com_o, seg_o, dp_o} !== {ecom, eseg, edp}) begin
        n_fail++;
        $display("FAIL %s k=%0d: com=%b seg=%h dp=%b, expected com=%b seg=%h dp=%b",
                 nm, k, com_o, seg_o, dp_o, ecom, eseg, edp);
      end
    end
  endtask

  task automatic wait_ready(input string nm);
    int t = 0;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL %s_ready_timeout: in_ready=%b, expected 1", nm, in_ready);
    end
  endtask

  // Drives one update and checks busy/ready across E..E+7
  task automatic accept(input string nm, input int s, input int m);
    int bad = 0;
    wait_ready(nm);
    in_valid = 1'b1; sec_i = 6'(s); min_i = 6'(m);
    @(posedge clk); #1;                   // edge E
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin     // after E .. E+6
      if (!(busy === 1'b1 && in_ready === 1'b0)) bad++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_busy: %0d of 7 cycles not busy, expected 0", nm, bad);
    end
    n_chk++;                              // after E+7
    if (!(busy === 1'b0 && in_ready === 1'b1)) begin
      n_fail++;
      $display("FAIL %s_done: busy=%b ready=%b, expected busy=0 ready=1", nm, busy, in_ready);
    end
    m_sec = (s > 59) ? 59 : s;
    m_min = (m > 59) ? 59 : m;
    m_blink = ~m_blink;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({com_o, seg_o, dp_o, in_ready, busy} !== {4'b1111, 7'h00, 1'b0, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_hold: com=%b seg=%h dp=%b rdy=%b busy=%b, expected 1111 00 0 1 0",
                 com_o, seg_o, dp_o, in_ready, busy);
      end
    end
    rst = 1'b0;
    check_scan("reset_scan", 16);
  endtask

  task automatic test_basic();
    accept("m12s34", 34, 12);
    check_scan("m12s34_scan", 16);
    accept("m5s9", 9, 5);
    check_scan("m5s9_scan", 16);
  endtask

  task automatic test_hold();
    wait_ready("hold");
    in_valid = 1'b1; sec_i = 6'd2; min_i = 6'd1;
    @(posedge clk); #1;                   // E
    sec_i = 6'd7; min_i = 6'd3;
    repeat (7) begin @(posedge clk); #1; end   // after E+7
    n_chk++;
    if (!(in_ready === 1'b1 && busy === 1'b0)) begin
      n_fail++;
      $display("FAIL hold_first_done: ready=%b busy=%b, expected 1 0", in_ready, busy);
    end
    m_sec = 2; m_min = 1; m_blink = ~m_blink;
    @(posedge clk); #1;                   // E+8: held request taken here
    in_valid = 1'b0;
    n_chk++;
    if (!(in_ready === 1'b0 && busy === 1'b1)) begin
      n_fail++;
      $display("FAIL hold_second_accept: ready=%b busy=%b, expected 0 1", in_ready, busy);
    end
    check_scan("hold_old_disp", 6);        // through E+14, old digits
    @(posedge clk); #1;                   // E+15
    n_chk++;
    if (!(in_ready === 1'b1 && busy === 1'b0)) begin
      n_fail++;
      $display("FAIL hold_second_done: ready=%b busy=%b, expected 1 0", in_ready, busy);
    end
    m_sec = 7; m_min = 3; m_blink = ~m_blink;
    check_scan("hold_new_disp", 16);
  endtask

  task automatic test_clamp();
    accept("clamp", 63, 60);
    check_scan("clamp_scan", 16);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      accept("rand", int'($urandom_range(63)), int'($urandom_range(63)));
      check_scan("rand_scan", 16);
    end
  endtask

  task automatic test_reset_mid_conv();
    wait_ready("midrst");
    in_valid = 1'b1; sec_i = 6'd48; min_i = 6'd27;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({com_o, seg_o, dp_o, in_ready, busy} !== {4'b1111, 7'h00, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_async: com=%b seg=%h dp=%b rdy=%b busy=%b, expected 1111 00 0 1 0",
               com_o, seg_o, dp_o, in_ready, busy);
    end
    m_sec = 0; m_min = 0; m_blink = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_scan("midrst_scan", 24);
    accept("blink1", 11, 22);
    check_scan("blink1_scan", 16);
    accept("blink2", 33, 44);
    check_scan("blink2_scan", 16);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_clamp();
    test_random();
    test_reset_mid_conv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
